// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler feeding two requesters into one multi-cycle multiplier.
// Ports: req handshake/op/operands/tag per requester, multiplier start/result, writeback handshake, flush.
module mul_sched #(
  parameter int PRF_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [9:0]           req0_op_f3,
  input  logic [9:0]           req1_op_f3,
  input  logic [63:0]          req0_op1,
  input  logic [63:0]          req0_op2,
  input  logic [63:0]          req1_op1,
  input  logic [63:0]          req1_op2,
  input  logic [PRF_WIDTH-1:0] req0_prd,
  input  logic [PRF_WIDTH-1:0] req1_prd,
  output logic                 mult_ready,
  output logic [9:0]           inst_op_f3,
  output logic [63:0]          mult_op1,
  output logic [63:0]          mult_op2,
  input  logic [63:0]          product_val,
  input  logic                 mult_finish,
  input  logic                 busy_i,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [63:0]          wb_data,
  output logic [PRF_WIDTH-1:0] wb_prd,
  output logic                 wb_src,
  input  logic                 flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 prio_q;
  logic                 kill_q, kill_d;
  logic [9:0]           op_q;
  logic [63:0]          op1_q, op2_q;
  logic [63:0]          data_q;
  logic [PRF_WIDTH-1:0] prd_q;
  logic                 src_q;
  logic [1:0]           gnt;
  logic                 cap;

  // prio_q names the requester that wins a tie.
  always_comb begin
    if (req_valid == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
    else                    gnt = req_valid;
  end

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    req_ready  = 2'b00;
    mult_ready = 1'b0;
    wb_valid   = 1'b0;
    cap        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst && !flush && !busy_i) req_ready = gnt;
        if (|req_ready) state_d = ISSUE;
      end
      ISSUE: begin
        if (flush) state_d = IDLE;
        else begin
          mult_ready = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (flush) kill_d = 1'b1;
        if (mult_finish) begin
          if (kill_q || flush) state_d = IDLE;
          else begin
            cap     = 1'b1;
            state_d = WB;
          end
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (flush || wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) kill_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      kill_q  <= 1'b0;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      data_q  <= '0;
      prd_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (|req_ready) begin
        op_q   <= req_ready[1] ? req1_op_f3 : req0_op_f3;
        op1_q  <= req_ready[1] ? req1_op1   : req0_op1;
        op2_q  <= req_ready[1] ? req1_op2   : req0_op2;
        prd_q  <= req_ready[1] ? req1_prd   : req0_prd;
        src_q  <= req_ready[1];
        prio_q <= req_ready[0];
      end
      if (cap) data_q <= product_val;
    end
  end

  assign inst_op_f3 = op_q;
  assign mult_op1   = op1_q;
  assign mult_op2   = op2_q;
  assign wb_data    = data_q;
  assign wb_prd     = prd_q;
  assign wb_src     = src_q;

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 SHALL have parameter PRF_WIDTH, default 6: width of the physical destination register tag.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports req_valid  input  2 and req_ready  output  2: per-requester request handshake; bit i belongs to requester i.
REQ-005 SHALL have ports req0_op_f3/req1_op_f3  input  10: {opcode[6:0], funct3[2:0]} of each request.
REQ-006 SHALL have ports req0_op1/req0_op2/req1_op1/req1_op2  input  64: operands of each request.
REQ-007 SHALL have ports req0_prd/req1_prd  input  PRF_WIDTH: destination tag of each request.
REQ-008 SHALL have ports mult_ready  output  1, inst_op_f3  output  10, mult_op1  output  64, mult_op2  output  64: start pulse and operands to the multi-cycle multiplier.
REQ-009 SHALL have ports product_val  input  64, mult_finish  input  1, busy_i  input  1: multiplier result, completion pulse, and busy status.
REQ-010 SHALL have ports wb_valid  output  1, wb_ready  input  1, wb_data  output  64, wb_prd  output  PRF_WIDTH, wb_src  output  1: writeback handshake, result, tag, and originating requester.
REQ-011 SHALL have port flush  input  1: kills any accepted, not-yet-written-back operation.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, WB.
REQ-013 In IDLE with flush=0 and busy_i=0, req_ready SHALL be one-hot to the granted requester with req_valid set; all other req_ready bits SHALL be 0.
REQ-014 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; after reset, requester 0 has priority.
REQ-015 On a valid&&ready handshake, op_f3, operands, prd, and the source index SHALL be latched, and the FSM SHALL move IDLE->ISSUE.
REQ-016 In ISSUE, mult_ready SHALL be 1 for exactly one cycle with the latched op and operands on inst_op_f3/mult_op1/mult_op2; the FSM then moves ISSUE->WAIT.
REQ-017 inst_op_f3/mult_op1/mult_op2 SHALL hold the latched values from ISSUE through WAIT.
REQ-018 In WAIT, on mult_finish=1, product_val SHALL be captured into wb_data, and the FSM SHALL move WAIT->WB.
REQ-019 mult_finish SHALL be ignored in IDLE, ISSUE and WB.
REQ-020 In WB, wb_valid=1 with stable wb_data/wb_prd/wb_src until wb_ready=1; then WB->IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle as the WB handshake. Minimum request-to-request spacing is completion + 1 cycle.
REQ-022 Latency: wb_valid SHALL rise exactly 1 cycle after the cycle in which mult_finish is seen in WAIT; mult_ready SHALL rise 1 cycle after acceptance.
REQ-023 flush in IDLE SHALL force req_ready=0 that cycle.
REQ-024 flush in ISSUE SHALL suppress mult_ready and return the FSM to IDLE.
REQ-025 flush in WAIT SHALL set a kill flag. The FSM stays in WAIT until mult_finish, discards the product, and returns to IDLE without asserting wb_valid.
REQ-026 flush in WB SHALL drop wb_valid the next cycle and return the FSM to IDLE, even if wb_ready is also 1 in that cycle.
REQ-027 The kill flag SHALL clear on entry to IDLE.
REQ-028 The round-robin pointer SHALL update only on an accepted handshake; flushed operations still count as granted.
REQ-029 The scheduler SHALL NOT decode or alter operands or results; width and sign handling belong to the multiplier.
REQ-030 The latched source index and wb_src SHALL use bit 0 for requester 0.

Reset
REQ-031 While rst=0, the FSM SHALL be in IDLE and the RR pointer at requester 0.
REQ-032 While rst=0, mult_ready, wb_valid, req_ready, wb_src and the kill flag SHALL be 0.
REQ-033 While rst=0, inst_op_f3, mult_op1, mult_op2, wb_data and wb_prd SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL abandon the operation with no writeback; a mult_finish arriving after reset release SHALL be ignored.

Verification
REQ-035 Bench SHALL use a behavioural multiplier with fixed 4-cycle start-to-finish latency, with busy_i high from mult_ready until mult_finish.
REQ-036 req0 mul (op_f3=10'b0110011000), op1=5, op2=-5, prd=7 -> one mult_ready pulse; wb_valid with wb_data=64'hFFFFFFFFFFFFFFE7, wb_prd=7, wb_src=0.
REQ-037 Both requesters valid continuously (req1 mulhu, op1=op2=-5; req0 mul, op1=3, op2=4, prd=2) -> grants alternate 0,1,0,1; req0 returns wb_data=12; req1 returns wb_data=64'hFFFFFFFFFFFFFFF6.
REQ-038 wb_ready held 0 for 5 cycles in WB -> wb_valid and wb_data stable; req_ready=0 throughout; accept only after the WB handshake.
REQ-039 flush pulsed 2 cycles after mult_ready -> no wb_valid; the next request is accepted only after the killed mult_finish and completes normally.
REQ-040 rst driven low during WAIT -> all outputs 0 immediately; a subsequent stray mult_finish produces no wb_valid.
